instr_encoder: RTL and testbench

Inverse of the core's instruction decoder: it accepts field-level instruction descriptions (operation, register indices, immediate) over a valid/ready stream and packs them into RV32I machine words. The words are buffered in a small FIFO and written sequentially into instruction memory from a programmable base word address. It serves as the program loader between the host/debug front end and the CPU's instruction memory, covering exactly the instruction subset the core decodes.

---
 rtl/instr_encoder_pkg.sv | 43 ++++
 rtl/instr_encoder_fifo.sv | 53 +++++
 rtl/instr_encoder.sv | 187 ++++++++++++++++++
 tb/tb_instr_encoder.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_encoder_pkg.sv
// Shared ISA constants for the instruction encoder: operation selects,
// RV32I opcode/funct fields, the NOP word and the loader FSM states.
package instr_encoder_pkg;

  typedef enum logic [4:0] {
    OP_ADDI, OP_XORI, OP_ORI, OP_ANDI, OP_SLTIU, OP_SLTI,
    OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD, OP_XOR, OP_OR, OP_AND, OP_SUB, OP_SLL, OP_SRL, OP_SRA, OP_SLTU, OP_SLT,
    OP_SW,
    OP_BNE, OP_BEQ, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU
  } op_e;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_SW   = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [2:0] {FMT_I, FMT_SH, FMT_R, FMT_S, FMT_B, FMT_BAD} fmt_e;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

endpackage

// File: rtl/instr_encoder_fifo.sv
// DEPTH x WIDTH synchronous FIFO; a push while full is taken only when a pop
// happens in the same cycle.
module enc_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_V = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [PW:0]      cnt;
  logic             do_push, do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == FULL_V);
  assign count   = cnt;
  assign rdata   = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (PW+1)'(1);
        2'b01:   cnt <= cnt - (PW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: packs field-level descriptors into RV32I words, buffers them
// and writes them to instruction memory from a programmable base address.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [12:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  input  logic              imem_stall,
  output logic              busy,
  output logic              done,
  output logic [7:0]        err_cnt
);

  localparam int unsigned CW = $clog2(DEPTH);
  localparam logic [CW+1:0] DEPTH_V = (CW+2)'(DEPTH);

  state_e            state;
  fmt_e              fmt;
  logic [2:0]        f3;
  logic [6:0]        f7;
  logic [31:0]       enc_word;
  logic              enc_bad;
  logic              accept;
  logic              s1_valid;
  logic [31:0]       s1_word;
  logic [31:0]       fifo_rdata;
  logic              fifo_full, fifo_empty;
  logic [CW:0]       fifo_count;
  logic [CW+1:0]     occ;
  logic              out_load;
  logic              retire;
  logic [ADDR_W-1:0] wr_addr;

  assign occ      = {1'b0, fifo_count} + {{(CW+1){1'b0}}, s1_valid};
  assign in_ready = (state == S_RUN) && (occ < DEPTH_V);
  assign accept   = in_valid & in_ready;
  assign retire   = imem_we & ~imem_stall;
  assign out_load = ~fifo_empty & (~imem_we | ~imem_stall);

  always_comb begin
    fmt = FMT_BAD;
    f3  = '0;
    f7  = F7_BASE;
    case (in_op)
      OP_ADDI:  begin fmt = FMT_I;  f3 = F3_ADD;  end
      OP_XORI:  begin fmt = FMT_I;  f3 = F3_XOR;  end
      OP_ORI:   begin fmt = FMT_I;  f3 = F3_OR;   end
      OP_ANDI:  begin fmt = FMT_I;  f3 = F3_AND;  end
      OP_SLTIU: begin fmt = FMT_I;  f3 = F3_SLTU; end
      OP_SLTI:  begin fmt = FMT_I;  f3 = F3_SLT;  end
      OP_SLLI:  begin fmt = FMT_SH; f3 = F3_SLL;  end
      OP_SRLI:  begin fmt = FMT_SH; f3 = F3_SR;   end
      OP_SRAI:  begin fmt = FMT_SH; f3 = F3_SR;  f7 = F7_ALT; end
      OP_ADD:   begin fmt = FMT_R;  f3 = F3_ADD;  end
      OP_XOR:   begin fmt = FMT_R;  f3 = F3_XOR;  end
      OP_OR:    begin fmt = FMT_R;  f3 = F3_OR;   end
      OP_AND:   begin fmt = FMT_R;  f3 = F3_AND;  end
      OP_SUB:   begin fmt = FMT_R;  f3 = F3_ADD; f7 = F7_ALT; end
      OP_SLL:   begin fmt = FMT_R;  f3 = F3_SLL;  end
      OP_SRL:   begin fmt = FMT_R;  f3 = F3_SR;   end
      OP_SRA:   begin fmt = FMT_R;  f3 = F3_SR;  f7 = F7_ALT; end
      OP_SLTU:  begin fmt = FMT_R;  f3 = F3_SLTU; end
      OP_SLT:   begin fmt = FMT_R;  f3 = F3_SLT;  end
      OP_SW:    begin fmt = FMT_S;  f3 = F3_SW;   end
      OP_BNE:   begin fmt = FMT_B;  f3 = F3_BNE;  end
      OP_BEQ:   begin fmt = FMT_B;  f3 = F3_BEQ;  end
      OP_BLT:   begin fmt = FMT_B;  f3 = F3_BLT;  end
      OP_BGE:   begin fmt = FMT_B;  f3 = F3_BGE;  end
      OP_BLTU:  begin fmt = FMT_B;  f3 = F3_BLTU; end
      OP_BGEU:  begin fmt = FMT_B;  f3 = F3_BGEU; end
      default:  fmt = FMT_BAD;
    endcase
  end

  always_comb begin
    enc_word = NOP_WORD;
    enc_bad  = 1'b0;
    case (fmt)
      FMT_I: begin
        enc_bad  = in_imm[12] != in_imm[11];
        enc_word = {in_imm[11:0], in_rs1, f3, in_rd, OPC_OP_IMM};
      end
      FMT_SH: begin
        enc_bad  = |in_imm[11:5];
        enc_word = {f7, in_imm[4:0], in_rs1, f3, in_rd, OPC_OP_IMM};
      end
      FMT_R: enc_word = {f7, in_rs2, in_rs1, f3, in_rd, OPC_OP};
      FMT_S: begin
        enc_bad  = in_imm[12] != in_imm[11];
        enc_word = {in_imm[11:5], in_rs2, in_rs1, f3, in_imm[4:0], OPC_STORE};
      end
      FMT_B: begin
        enc_bad  = in_imm[0];
        enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, f3,
                    in_imm[4:1], in_imm[11], OPC_BRANCH};
      end
      default: enc_bad = 1'b1;
    endcase
    if (enc_bad) enc_word = NOP_WORD;
  end

  enc_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (s1_valid),
    .wdata (s1_word),
    .pop   (out_load),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // in_ready reserves a slot for stage 1, so its push never meets a full FIFO
  // unless the output register pops in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_word    <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) s1_word <= enc_word;
      if (out_load) begin
        imem_we    <= 1'b1;
        imem_addr  <= wr_addr;
        imem_wdata <= fifo_rdata;
      end else if (retire) begin
        imem_we <= 1'b0;
      end
    end
  end

  // wr_addr advances when a word enters the output register; each such word
  // retires exactly once, so this matches counting retirements.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      err_cnt <= '0;
      wr_addr <= '0;
    end else begin
      done <= 1'b0;
      if (accept && enc_bad && err_cnt != '1) err_cnt <= err_cnt + 8'd1;
      if (out_load) wr_addr <= wr_addr + ADDR_W'(1);
      case (state)
        S_IDLE: if (start) begin
          state   <= S_RUN;
          busy    <= 1'b1;
          err_cnt <= '0;
          wr_addr <= base_addr;
        end
        S_RUN: if (accept && in_last) state <= S_DRAIN;
        S_DRAIN: if (!s1_valid && fifo_empty && !(imem_we && imem_stall)) begin
          state <= S_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder: encodings, illegal
// descriptors, backpressure, address wrap and mid-session reset.
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [4:0]        in_op = '0, in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [12:0]       in_imm = '0;
  logic              in_last = 1'b0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              imem_stall = 1'b0;
  logic              busy, done;
  logic [7:0]        err_cnt;

  instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .imem_stall(imem_stall), .busy(busy), .done(done), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    int                cyc;
  } wr_t;
  wr_t wq[$];
  int  done_cnt = 0;

  // A write is logged on the negedge before the edge that retires it.
  always @(negedge clk) begin
    if (!rst && imem_we && !imem_stall) begin
      wr_t w;
      w.addr = imem_addr;
      w.data = imem_wdata;
      w.cyc  = cyc;
      wq.push_back(w);
    end
    if (done) done_cnt++;
  end

  int chk = 0;
  int pass = 0;

  function automatic logic [31:0] addi_w(int rd, int imm);
    logic [31:0] r;
    r = {imm[11:0], 5'd0, 3'b000, rd[4:0], 7'b0010011};
    return r;
  endfunction

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(logic [ADDR_W-1:0] base);
    start = 1'b1;
    base_addr = base;
    tick(1);
    start = 1'b0;
  endtask

  task automatic send(logic [4:0] op, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                      logic [12:0] imm, logic last, output int acc_cyc);
    in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_last = last;
    in_valid = 1'b1;
    acc_cyc = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        break;
      end
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    if (acc_cyc < 0) begin
      chk++;
      $display("FAIL send_timeout op=%0d got no in_ready, expected acceptance", op);
    end
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
    end
    @(posedge clk);
    #1;
    if (!seen) begin
      chk++;
      $display("FAIL done_timeout got no done pulse, expected one");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    chk++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready got %b exp 0", in_ready); else pass++;
    chk++; if (imem_we !== 1'b0) $display("FAIL rst_imem_we got %b exp 0", imem_we); else pass++;
    chk++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL rst_busy_done got %b%b exp 00", busy, done); else pass++;
    chk++; if (imem_addr !== '0 || imem_wdata !== '0) $display("FAIL rst_imem got %h/%h exp 0/0", imem_addr, imem_wdata); else pass++;
    chk++; if (err_cnt !== 8'd0) $display("FAIL rst_err_cnt got %0d exp 0", err_cnt); else pass++;
    rst = 1'b0;
    tick(1);
    chk++; if (in_ready !== 1'b0) $display("FAIL idle_in_ready got %b exp 0", in_ready); else pass++;
  endtask

  task automatic test_single();
    logic [31:0] exp_d [5];
    int idx0, d0, acc;
    exp_d = '{32'h00500093, 32'h402081B3, 32'h0020A423, 32'hFE208EE3, 32'h4032D293};
    idx0 = wq.size();
    d0 = done_cnt;
    do_start(10'h010);
    chk++; if (busy !== 1'b1) $display("FAIL start_busy got %b exp 1", busy); else pass++;
    send(OP_ADDI, 5'd1, 5'd0, 5'd0, 13'd5, 1'b0, acc);
    for (int i = 0; i < 10 && wq.size() <= idx0; i++) @(negedge clk);
    chk++;
    if (wq.size() <= idx0) $display("FAIL latency got no write, expected write 2 cycles after accept");
    else if (wq[idx0].cyc - acc !== 2) $display("FAIL latency got %0d exp 2", wq[idx0].cyc - acc);
    else pass++;
    tick(1);
    send(OP_SUB,  5'd3, 5'd1, 5'd2, 13'd0, 1'b0, acc);
    send(OP_SW,   5'd0, 5'd1, 5'd2, 13'd8, 1'b0, acc);
    send(OP_BEQ,  5'd0, 5'd1, 5'd2, 13'h1FFC, 1'b0, acc);
    send(OP_SRAI, 5'd5, 5'd5, 5'd0, 13'd3, 1'b1, acc);
    wait_done();
    chk++; if (busy !== 1'b0) $display("FAIL single_busy_end got %b exp 0", busy); else pass++;
    tick(3);
    chk++; if (done_cnt - d0 !== 1) $display("FAIL single_done_pulses got %0d exp 1", done_cnt - d0); else pass++;
    chk++; if (wq.size() - idx0 !== 5) $display("FAIL single_nwrites got %0d exp 5", wq.size() - idx0); else pass++;
    for (int k = 0; k < 5; k++) begin
      chk++;
      if (idx0 + k >= wq.size()) $display("FAIL single_word%0d got none exp %h", k, exp_d[k]);
      else if (wq[idx0+k].data !== exp_d[k] || wq[idx0+k].addr !== ADDR_W'(10'h010 + k))
        $display("FAIL single_word%0d got %h@%h exp %h@%h", k, wq[idx0+k].data, wq[idx0+k].addr,
                 exp_d[k], 10'h010 + k);
      else pass++;
    end
    chk++; if (err_cnt !== 8'd0) $display("FAIL single_err_cnt got %0d exp 0", err_cnt); else pass++;
  endtask

  task automatic test_illegal();
    logic [31:0] exp_d [5];
    int idx0, acc;
    exp_d = '{NOP_WORD, NOP_WORD, NOP_WORD, 32'hFFF00093, NOP_WORD};
    idx0 = wq.size();
    do_start(10'h020);
    send(OP_SLLI, 5'd1, 5'd1, 5'd0, 13'd40, 1'b0, acc);
    chk++; if (err_cnt !== 8'd1) $display("FAIL ill_slli_err got %0d exp 1", err_cnt); else pass++;
    send(OP_BNE, 5'd0, 5'd1, 5'd2, 13'd3, 1'b0, acc);
    chk++; if (err_cnt !== 8'd2) $display("FAIL ill_bne_err got %0d exp 2", err_cnt); else pass++;
    send(5'd31, 5'd1, 5'd1, 5'd1, 13'd0, 1'b0, acc);
    send(OP_ADDI, 5'd1, 5'd0, 5'd0, 13'h1FFF, 1'b0, acc);
    send(OP_ADDI, 5'd1, 5'd0, 5'd0, 13'h0800, 1'b1, acc);
    wait_done();
    chk++; if (err_cnt !== 8'd4) $display("FAIL ill_err_final got %0d exp 4", err_cnt); else pass++;
    chk++; if (wq.size() - idx0 !== 5) $display("FAIL ill_nwrites got %0d exp 5", wq.size() - idx0); else pass++;
    for (int k = 0; k < 5; k++) begin
      chk++;
      if (idx0 + k >= wq.size()) $display("FAIL ill_word%0d got none exp %h", k, exp_d[k]);
      else if (wq[idx0+k].data !== exp_d[k] || wq[idx0+k].addr !== ADDR_W'(10'h020 + k))
        $display("FAIL ill_word%0d got %h@%h exp %h@%h", k, wq[idx0+k].data, wq[idx0+k].addr,
                 exp_d[k], 10'h020 + k);
      else pass++;
    end
  endtask

  task automatic test_backpressure();
    int idx0, acc, n_acc, i;
    bit acc_now;
    idx0 = wq.size();
    do_start(10'h040);
    chk++; if (err_cnt !== 8'd0) $display("FAIL start_clears_err got %0d exp 0", err_cnt); else pass++;
    imem_stall = 1'b1;
    n_acc = 0;
    i = 1;
    in_op = OP_ADDI; in_rs1 = 5'd0; in_rs2 = 5'd0; in_last = 1'b0;
    in_rd = 5'(i); in_imm = 13'(i); in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      acc_now = in_ready;
      @(posedge clk);
      #1;
      if (acc_now) begin
        n_acc++;
        i++;
        in_rd = 5'(i);
        in_imm = 13'(i);
      end
    end
    in_valid = 1'b0;
    chk++; if (n_acc !== DEPTH + 1) $display("FAIL bp_accepted got %0d exp %0d", n_acc, DEPTH + 1); else pass++;
    chk++; if (wq.size() !== idx0) $display("FAIL bp_no_retire got %0d exp 0", wq.size() - idx0); else pass++;
    chk++;
    if (imem_we !== 1'b1 || imem_addr !== 10'h040 || imem_wdata !== addi_w(1, 1))
      $display("FAIL bp_hold got we=%b %h@%h exp we=1 %h@040", imem_we, imem_wdata, imem_addr, addi_w(1, 1));
    else pass++;
    imem_stall = 1'b0;
    for (int k = 6; k <= 8; k++) send(OP_ADDI, 5'(k), 5'd0, 5'd0, 13'(k), k == 8, acc);
    wait_done();
    chk++; if (wq.size() - idx0 !== 8) $display("FAIL bp_nwrites got %0d exp 8", wq.size() - idx0); else pass++;
    for (int k = 0; k < 8; k++) begin
      chk++;
      if (idx0 + k >= wq.size()) $display("FAIL bp_word%0d got none exp %h", k, addi_w(k + 1, k + 1));
      else if (wq[idx0+k].data !== addi_w(k + 1, k + 1) || wq[idx0+k].addr !== ADDR_W'(10'h040 + k))
        $display("FAIL bp_word%0d got %h@%h exp %h@%h", k, wq[idx0+k].data, wq[idx0+k].addr,
                 addi_w(k + 1, k + 1), 10'h040 + k);
      else if (k > 0 && wq[idx0+k].cyc !== wq[idx0+k-1].cyc + 1)
        $display("FAIL bp_rate%0d got gap %0d exp 1", k, wq[idx0+k].cyc - wq[idx0+k-1].cyc);
      else pass++;
    end
  endtask

  task automatic test_wrap();
    int idx0, acc;
    idx0 = wq.size();
    do_start(10'h3FF);
    send(OP_ADDI, 5'd7, 5'd0, 5'd0, 13'd1, 1'b0, acc);
    send(OP_ADDI, 5'd8, 5'd0, 5'd0, 13'd2, 1'b1, acc);
    wait_done();
    chk++;
    if (wq.size() - idx0 !== 2) $display("FAIL wrap_nwrites got %0d exp 2", wq.size() - idx0);
    else if (wq[idx0].addr !== 10'h3FF || wq[idx0].data !== 32'h00100393)
      $display("FAIL wrap_first got %h@%h exp 00100393@3ff", wq[idx0].data, wq[idx0].addr);
    else pass++;
    chk++;
    if (wq.size() - idx0 < 2) $display("FAIL wrap_second got none exp 00200413@000");
    else if (wq[idx0+1].addr !== 10'h000 || wq[idx0+1].data !== 32'h00200413)
      $display("FAIL wrap_second got %h@%h exp 00200413@000", wq[idx0+1].data, wq[idx0+1].addr);
    else pass++;
  endtask

  task automatic test_reset_mid();
    int idx0, d0, acc;
    do_start(10'h100);
    imem_stall = 1'b1;
    for (int k = 1; k <= 4; k++) send(OP_ADDI, 5'(k), 5'd0, 5'd0, 13'(k), 1'b0, acc);
    tick(3);
    chk++; if (busy !== 1'b1 || imem_we !== 1'b1) $display("FAIL mid_pre got busy=%b we=%b exp 1 1", busy, imem_we); else pass++;
    idx0 = wq.size();
    d0 = done_cnt;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    imem_stall = 1'b0;
    tick(10);
    chk++; if (wq.size() !== idx0) $display("FAIL mid_no_write got %0d exp 0", wq.size() - idx0); else pass++;
    chk++; if (done_cnt !== d0) $display("FAIL mid_no_done got %0d exp 0", done_cnt - d0); else pass++;
    chk++;
    if (busy !== 1'b0 || imem_we !== 1'b0 || in_ready !== 1'b0)
      $display("FAIL mid_idle got busy=%b we=%b rdy=%b exp 0 0 0", busy, imem_we, in_ready);
    else pass++;
    do_start(10'h200);
    send(OP_ADDI, 5'd9, 5'd0, 5'd0, 13'd9, 1'b1, acc);
    wait_done();
    chk++;
    if (wq.size() - idx0 !== 1) $display("FAIL mid_recover_n got %0d exp 1", wq.size() - idx0);
    else if (wq[idx0].addr !== 10'h200 || wq[idx0].data !== 32'h00900493)
      $display("FAIL mid_recover got %h@%h exp 00900493@200", wq[idx0].data, wq[idx0].addr);
    else pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_illegal();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
